// File: rtl/processor_control_unit.sv
// Instruction sequencer: holds PC/IR, fetches from a synchronous instruction memory
// and drives every datapath control as a Moore decode of state plus IR.
module processor_control_unit #(
    parameter int         PC_WIDTH    = 7,
    parameter logic [2:0] ALU_ADD_SEL = 3'd1,
    parameter logic [2:0] ALU_SUB_SEL = 3'd2
) (
    input  logic                Clock,
    input  logic                Reset_n,
    output logic [PC_WIDTH-1:0] IM_Addr,
    input  logic [15:0]         IM_Data,
    output logic [7:0]          D_Addr,
    output logic                D_Wr,
    output logic                RF_s,
    output logic [3:0]          RF_W_Addr,
    output logic                RF_W_en,
    output logic [3:0]          RF_Ra_Addr,
    output logic [3:0]          RF_Rb_Addr,
    output logic [2:0]          ALU_s0,
    output logic                Halted,
    output logic [3:0]          State,
    output logic [PC_WIDTH-1:0] PC,
    output logic [15:0]         IR
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [15:0]         r_ir;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory samples PC at the end of FETCH, so its data is on IM_Data during DECODE.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pc <= '0;
            r_ir <= '0;
        end else begin
            if (r_state == S_FETCH) begin
                r_pc <= r_pc + PC_ONE;
            end
            if (r_state == S_DECODE) begin
                r_ir <= IM_Data;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (IM_Data[15:12])
                    4'h0:    w_next = S_NOOP;
                    4'h1:    w_next = S_STORE;
                    4'h2:    w_next = S_LOAD_A;
                    4'h3:    w_next = S_ADD;
                    4'h4:    w_next = S_SUB;
                    4'h5:    w_next = S_HALT;
                    default: w_next = S_NOOP;
                endcase
            end
            S_NOOP:   w_next = S_FETCH;
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = S_FETCH;
            S_STORE:  w_next = S_FETCH;
            S_ADD:    w_next = S_FETCH;
            S_SUB:    w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;
        endcase
    end

    always_comb begin
        D_Addr     = '0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_Addr = '0;
        RF_Rb_Addr = '0;
        ALU_s0     = '0;
        Halted     = 1'b0;
        case (r_state)
            S_LOAD_A, S_LOAD_B: begin
                D_Addr    = r_ir[11:4];
                RF_s      = 1'b1;
                RF_W_Addr = r_ir[3:0];
                RF_W_en   = (r_state == S_LOAD_B);
            end
            S_STORE: begin
                D_Addr     = r_ir[11:4];
                RF_Ra_Addr = r_ir[3:0];
                D_Wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_Addr = r_ir[11:8];
                RF_Rb_Addr = r_ir[7:4];
                RF_W_Addr  = r_ir[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (r_state == S_ADD) ? ALU_ADD_SEL : ALU_SUB_SEL;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign IM_Addr = r_pc;
    assign PC      = r_pc;
    assign IR      = r_ir;
    assign State   = r_state;

endmodule

// File: tb/tb_processor_control_unit.sv
// Self-checking bench for processor_control_unit: directed program, random programs
// against an instruction-level reference model, mid-instruction reset and PC wrap.
module tb_processor_control_unit;

    logic        Clock;
    logic        Reset_n;
    logic [6:0]  IM_Addr;
    logic [15:0] IM_Data;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_W_Addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [2:0]  ALU_s0;
    logic        Halted;
    logic [3:0]  State;
    logic [6:0]  PC;
    logic [15:0] IR;

    logic [15:0] mem [128];
    logic [60:0] obs;
    int          checks;
    int          errors;

    processor_control_unit dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .IM_Addr    (IM_Addr),
        .IM_Data    (IM_Data),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_Addr  (RF_W_Addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .ALU_s0     (ALU_s0),
        .Halted     (Halted),
        .State      (State),
        .PC         (PC),
        .IR         (IR)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Synchronous instruction memory: address captured on the rising edge.
    always @(posedge Clock) begin
        IM_Data <= mem[IM_Addr];
    end

    assign obs = {State, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en, RF_Ra_Addr,
                  RF_Rb_Addr, ALU_s0, Halted, IM_Addr, PC, IR};

    // Expected observable vector for cycle 'ph' of the instruction 'w' fetched from 'pc'.
    function automatic logic [60:0] model(input int ph, input logic [15:0] w,
                                          input logic [15:0] prev_ir, input int pc);
        logic [3:0]  st;
        logic [7:0]  da;
        logic        dwr, rfs, wen, hlt;
        logic [3:0]  wa, ra, rb;
        logic [2:0]  alu;
        logic [6:0]  pcv;
        logic [15:0] irv;
        st = 4'd0; da = 8'd0; dwr = 1'b0; rfs = 1'b0; wen = 1'b0; hlt = 1'b0;
        wa = 4'd0; ra = 4'd0; rb = 4'd0; alu = 3'd0;
        pcv = 7'((pc + 1) % 128);
        irv = w;
        if (ph == 0) begin
            st = 4'd1; pcv = 7'(pc); irv = prev_ir;
        end else if (ph == 1) begin
            st = 4'd2; irv = prev_ir;
        end else begin
            case (w[15:12])
                4'h1: begin st = 4'd6; da = w[11:4]; ra = w[3:0]; dwr = 1'b1; end
                4'h2: begin
                    st = (ph == 2) ? 4'd4 : 4'd5;
                    da = w[11:4]; rfs = 1'b1; wa = w[3:0]; wen = (ph == 3);
                end
                4'h3, 4'h4: begin
                    st  = (w[15:12] == 4'h3) ? 4'd7 : 4'd8;
                    alu = (w[15:12] == 4'h3) ? 3'd1 : 3'd2;
                    ra = w[11:8]; rb = w[7:4]; wa = w[3:0]; wen = 1'b1;
                end
                4'h5:    begin st = 4'd9; hlt = 1'b1; end
                default: st = 4'd3;
            endcase
        end
        return {st, da, dwr, rfs, wa, wen, ra, rb, alu, hlt, pcv, pcv, irv};
    endfunction

    task automatic apply_reset();
        Reset_n = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        Reset_n = 1'b0;
        @(negedge Clock);
        checks++;
        if (obs !== 61'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs, 61'd0);
        end
        Reset_n = 1'b1;
        #1;
        checks++;
        if (State !== 4'd0) begin
            errors++;
            $display("[TB] FAIL init_after_release: State got %0d expected 0", State);
        end
        @(negedge Clock);
        checks++;
        if (State !== 4'd1 || IM_Addr !== 7'd0) begin
            errors++;
            $display("[TB] FAIL first_fetch: State %0d IM_Addr %0d expected 1/0", State, IM_Addr);
        end
    endtask

    task automatic test_directed_program();
        logic [15:0] w;
        logic [15:0] prev_ir;
        logic [60:0] expv;
        int          pc;
        int          ncyc;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        mem[0] = 16'h21A5; mem[1] = 16'h3AB0; mem[2] = 16'h4123;
        mem[3] = 16'h1000; mem[4] = 16'hF123; mem[5] = 16'h5000;
        apply_reset();
        @(negedge Clock);
        pc = 0; prev_ir = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            w = mem[pc];
            ncyc = (w[15:12] == 4'h2) ? 4 : 3;
            for (int ph = 0; ph < ncyc; ph++) begin
                expv = model(ph, w, prev_ir, pc);
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("[TB] FAIL directed instr %0d phase %0d: got %h expected %h", k, ph, obs, expv);
                end
                @(negedge Clock);
            end
            prev_ir = w;
            pc = (pc + 1) % 128;
        end
        expv = model(2, 16'h5000, 16'h0000, 5);
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL halt_hold cycle %0d: got %h expected %h", c, obs, expv);
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_random_programs();
        logic [15:0] w;
        logic [15:0] prev_ir;
        logic [60:0] expv;
        logic [3:0]  op;
        int          pc;
        int          ncyc;
        for (int run = 0; run < 3; run++) begin
            for (int i = 0; i < 128; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'h5) op = 4'h3;
                mem[i] = {op, 12'($urandom)};
            end
            apply_reset();
            @(negedge Clock);
            pc = 0; prev_ir = 16'h0000;
            for (int k = 0; k < 60; k++) begin
                w = mem[pc];
                ncyc = (w[15:12] == 4'h2) ? 4 : 3;
                for (int ph = 0; ph < ncyc; ph++) begin
                    expv = model(ph, w, prev_ir, pc);
                    checks++;
                    if (obs !== expv) begin
                        errors++;
                        $display("[TB] FAIL random run %0d instr %0d phase %0d: got %h expected %h",
                                 run, k, ph, obs, expv);
                    end
                    checks++;
                    if (D_Wr === 1'b1 && RF_W_en === 1'b1) begin
                        errors++;
                        $display("[TB] FAIL write_exclusive: D_Wr %b RF_W_en %b expected not both 1", D_Wr, RF_W_en);
                    end
                    @(negedge Clock);
                end
                prev_ir = w;
                pc = (pc + 1) % 128;
            end
        end
    endtask

    task automatic test_reset_mid_add();
        logic [60:0] expv;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        mem[0] = 16'h3AB0;
        apply_reset();
        @(negedge Clock);
        @(negedge Clock);
        @(negedge Clock);
        expv = model(2, 16'h3AB0, 16'h0000, 0);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL add_before_reset: got %h expected %h", obs, expv);
        end
        #1 Reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 61'd0) begin
            errors++;
            $display("[TB] FAIL async_reset_mid_add: got %h expected %h", obs, 61'd0);
        end
        @(negedge Clock);
        Reset_n = 1'b1;
        #1;
        checks++;
        if (State !== 4'd0) begin
            errors++;
            $display("[TB] FAIL init_after_mid_reset: State got %0d expected 0", State);
        end
        @(negedge Clock);
        checks++;
        if (State !== 4'd1 || IM_Addr !== 7'd0) begin
            errors++;
            $display("[TB] FAIL fetch_after_mid_reset: State %0d IM_Addr %0d expected 1/0", State, IM_Addr);
        end
    endtask

    task automatic test_pc_wrap();
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        apply_reset();
        @(negedge Clock);
        for (int k = 0; k < 130; k++) begin
            checks++;
            if (State !== 4'd1 || IM_Addr !== 7'(k % 128)) begin
                errors++;
                $display("[TB] FAIL pc_wrap step %0d: State %0d IM_Addr %0d expected 1/%0d",
                         k, State, IM_Addr, k % 128);
            end
            @(negedge Clock);
            @(negedge Clock);
            @(negedge Clock);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        Reset_n = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        test_reset();
        test_directed_program();
        test_random_programs();
        test_reset_mid_add();
        test_pc_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/processor_control_unit.md
Name: processor_control_unit

Overview:
- Instruction-sequencing stage directly upstream of the processor datapath.
- Holds the program counter (PC) and the instruction register (IR), and fetches 16-bit instructions from a synchronous instruction memory.
- Decodes each instruction and drives every datapath control input through a Moore state machine: data-memory address/write, register-file mux select, write/read addresses, write enable and ALU select.

Parameters:
PC_WIDTH, 7, instruction-memory address width; PC wraps modulo 2^PC_WIDTH
ALU_ADD_SEL, 3'd1, ALU_s0 code for addition
ALU_SUB_SEL, 3'd2, ALU_s0 code for subtraction

Ports:
Clock  input  1  system clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
IM_Addr  output  PC_WIDTH  instruction-memory address (equals PC)
IM_Data  input  16  instruction-memory read data, valid one cycle after address is presented
D_Addr  output  8  data-memory address
D_Wr  output  1  data-memory write enable
RF_s  output  1  register-file write mux select: 0 = ALU, 1 = memory
RF_W_Addr  output  4  register-file write address
RF_W_en  output  1  register-file write enable
RF_Ra_Addr  output  4  register-file A read address
RF_Rb_Addr  output  4  register-file B read address
ALU_s0  output  3  ALU operation select
Halted  output  1  high while in HALT
State  output  4  current state encoding (debug)
PC  output  PC_WIDTH  program counter (debug)
IR  output  16  instruction register (debug)

Behaviour:
- Reset:
  - One clock domain; reset is asynchronous and active-low.
  - Reset_n=0 forces State=INIT, PC=0 and IR=0 immediately.
  - All datapath outputs and Halted read 0 during reset, with no clock edge required.
  - This holds mid-instruction: D_Wr and RF_W_en drop at once, so no write commits.
- Outputs:
  - Pure Moore decode of state plus IR.
  - Any control or address not listed for a state is 0.
  - IM_Addr = PC at all times.
- State encoding: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
- Transitions:
  - INIT -> FETCH, one cycle after reset release.
  - FETCH: memory samples IM_Addr; PC <= PC+1 at end of cycle; wraps from 2^PC_WIDTH-1 to 0. -> DECODE.
  - DECODE: IR <= IM_Data at end of cycle. Next state is selected from IM_Data[15:12]:
    - 0 -> NOOP
    - 1 -> STORE
    - 2 -> LOAD_A
    - 3 -> ADD
    - 4 -> SUB
    - 5 -> HALT
    - 6..F -> NOOP
  - NOOP, STORE, LOAD_B, ADD, SUB -> FETCH.
  - LOAD_A -> LOAD_B.
  - HALT -> HALT; only reset exits HALT.
- Instruction fields:
  - LOAD (0010 aaaaaaaa dddd), two cycles for synchronous memory read:
    - LOAD_A: D_Addr=IR[11:4], RF_s=1, RF_W_Addr=IR[3:0], RF_W_en=0.
    - LOAD_B: same as LOAD_A but RF_W_en=1.
  - STORE (0001 aaaaaaaa rrrr): D_Addr=IR[11:4], RF_Ra_Addr=IR[3:0], D_Wr=1 for exactly one cycle.
  - ADD (0011 aaaa bbbb dddd): RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], ALU_s0=ALU_ADD_SEL, RF_s=0, RF_W_en=1 for one cycle.
  - SUB: same fields as ADD, with ALU_s0=ALU_SUB_SEL.
  - HALT: Halted=1; all enables 0.
- PC behaviour:
  - PC is not incremented in HALT; it holds the HALT address + 1.
  - PC changes only in FETCH.
- Latency in cycles, FETCH through last execute state:
  - NOOP, STORE, ADD, SUB: 3.
  - LOAD: 4.
  - First FETCH begins 1 cycle after reset release (INIT).
- Invariants:
  - D_Wr and RF_W_en are never high in the same cycle.
  - Neither is high outside STORE, LOAD_B, ADD or SUB.

Test Plan:
1. Reset_n=0 asserted between clock edges during ADD -> D_Wr, RF_W_en, ALU_s0 and State read 0 before the next edge, with PC=0 and IR=0; after release, State goes 0 -> 1 and IM_Addr=0.
2. Word0=16'h21A5 (LOAD) -> the following must hold:
   - FETCH: IM_Addr=0.
   - DECODE, then IR=16'h21A5.
   - LOAD_A: D_Addr=8'h1A, RF_s=1, RF_W_en=0.
   - LOAD_B: RF_W_en=1, RF_W_Addr=5.
   - PC=1 throughout, then FETCH.
3. Word1=16'h3AB0 (ADD) -> one ADD cycle with RF_Ra_Addr=A, RF_Rb_Addr=B, RF_W_Addr=0, ALU_s0=1, RF_s=0, RF_W_en=1. Word2=16'h4123 (SUB) -> Ra=1, Rb=2, Rd=3, ALU_s0=2.
4. Word3=16'h1000 (STORE) -> exactly one cycle with D_Addr=8'h00, RF_Ra_Addr=0, D_Wr=1, RF_W_en=0. Word4=16'hF123 -> NOOP cycle with all controls 0.
5. Word5=16'h5000 (HALT) -> from the HALT cycle on: State=9, Halted=1 and PC=6 held for 20 cycles, with no enable ever asserted and IM_Addr frozen.
6. Memory filled with 16'h0000 (NOOP) -> IM_Addr advances by 1 every 3 cycles: 0, 1, …, 127, then wraps to 0.
